// File: rtl/somasub_sweep_checker_pkg.sv
// Shared definitions for the SOMASUB sweep checker.
//   state_t  : checker FSM states
//   MODE_*   : sweep mode encodings on the 2-bit mode input
//   OP_*     : operation select driven to SOMASUB
package somasub_sweep_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ADD  = 2'd0;
    localparam logic [1:0] MODE_SUB  = 2'd1;
    localparam logic [1:0] MODE_BOTH = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/somasub_sweep_checker_ref_model.sv
// Combinational golden model of the SOMASUB add/sub unit.
//   a_i, b_i    : operands
//   op_i        : 0 = add, 1 = sub
//   exp_r_o     : expected result
//   exp_ovf_o   : expected carry-out (add) or borrow (sub)
//   exp_zero_o  : expected zero flag
//   exp_sinal_o : expected sign flag (result MSB)
module somasub_ref_model
    import somasub_sweep_checker_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    output logic [WIDTH-1:0] exp_r_o,
    output logic             exp_ovf_o,
    output logic             exp_zero_o,
    output logic             exp_sinal_o
);

    logic [WIDTH:0] full;

    // The extra top bit is the carry for add and the borrow (a < b) for sub.
    always_comb begin
        if (op_i == OP_SUB) begin
            full = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            full = {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign exp_r_o     = full[WIDTH-1:0];
    assign exp_ovf_o   = full[WIDTH];
    assign exp_zero_o  = (full[WIDTH-1:0] == '0);
    assign exp_sinal_o = full[WIDTH-1];

endmodule

// File: rtl/somasub_sweep_checker.sv
// Exhaustive sweep initiator/checker for the combinational SOMASUB unit.
//   clk, rst         : clock, synchronous active-high reset
//   start, mode      : begin a sweep (add / sub / add-then-sub)
//   A, B, op         : registered stimulus to SOMASUB
//   R, bit_overflow, zero, sinal : SOMASUB response
//   busy, done       : sweep status
//   err_count        : saturating count of mismatching vectors
//   vec_count        : vectors checked this sweep
//   first_err_*      : capture of the first mismatching vector
module somasub_sweep_checker
    import somasub_sweep_checker_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic                 op,
    input  logic [WIDTH-1:0]     R,
    input  logic                 bit_overflow,
    input  logic                 zero,
    input  logic                 sinal,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_W-1:0]     err_count,
    output logic [2*WIDTH+1:0]   vec_count,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b,
    output logic                 first_err_op
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 op_q, op_d;
    logic                 both_q, both_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [2*WIDTH+1:0]   vec_q, vec_d;
    logic                 fev_q, fev_d;
    logic [WIDTH-1:0]     fea_q, fea_d;
    logic [WIDTH-1:0]     feb_q, feb_d;
    logic                 feo_q, feo_d;

    logic [WIDTH-1:0]     exp_r;
    logic                 exp_ovf;
    logic                 exp_zero;
    logic                 exp_sinal;
    logic                 mismatch;

    somasub_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a_i         (a_q),
        .b_i         (b_q),
        .op_i        (op_q),
        .exp_r_o     (exp_r),
        .exp_ovf_o   (exp_ovf),
        .exp_zero_o  (exp_zero),
        .exp_sinal_o (exp_sinal)
    );

    assign mismatch = (R != exp_r) || (bit_overflow != exp_ovf) ||
                      (zero != exp_zero) || (sinal != exp_sinal);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        both_d  = both_q;
        err_d   = err_q;
        vec_d   = vec_q;
        fev_d   = fev_q;
        fea_d   = fea_q;
        feb_d   = feb_q;
        feo_d   = feo_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = '0;
                    b_d     = '0;
                    op_d    = (mode == MODE_SUB) ? OP_SUB : OP_ADD;
                    // Mode 3 is reserved and behaves like MODE_BOTH.
                    both_d  = (mode != MODE_ADD) && (mode != MODE_SUB);
                    err_d   = '0;
                    vec_d   = '0;
                    fev_d   = 1'b0;
                    fea_d   = '0;
                    feb_d   = '0;
                    feo_d   = 1'b0;
                end
            end
            RUN: begin
                vec_d = vec_q + (2*WIDTH+2)'(1);
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fea_d = a_q;
                        feb_d = b_q;
                        feo_d = op_q;
                    end
                end
                // A is the inner loop, B the outer, op outermost.
                if (a_q != '1) begin
                    a_d = a_q + WIDTH'(1);
                end else if (b_q != '1) begin
                    a_d = '0;
                    b_d = b_q + WIDTH'(1);
                end else if (both_q && (op_q == OP_ADD)) begin
                    a_d  = '0;
                    b_d  = '0;
                    op_d = OP_SUB;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            both_q  <= 1'b0;
            err_q   <= '0;
            vec_q   <= '0;
            fev_q   <= 1'b0;
            fea_q   <= '0;
            feb_q   <= '0;
            feo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            both_q  <= both_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            fev_q   <= fev_d;
            fea_q   <= fea_d;
            feb_q   <= feb_d;
            feo_q   <= feo_d;
        end
    end

    assign A               = a_q;
    assign B               = b_q;
    assign op              = op_q;
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign err_count       = err_q;
    assign vec_count       = vec_q;
    assign first_err_valid = fev_q;
    assign first_err_a     = fea_q;
    assign first_err_b     = feb_q;
    assign first_err_op    = feo_q;

endmodule
